// File: rtl/lap_timer.sv
// Stopwatch core: up/down minute:second counter with countdown expiry,
// field-by-field adjust and a first-word-fall-through lap-capture FIFO.
module lap_timer #(
    parameter int MIN_MOD   = 60,
    parameter int SEC_MOD   = 60,
    parameter int MIN_W     = 7,
    parameter int SEC_W     = 6,
    parameter int LAP_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         en_tick,
    input  logic                         en_adj,
    input  logic                         start_stop,
    input  logic                         lap,
    input  logic                         clear,
    input  logic                         dir,
    input  logic                         adj,
    input  logic                         sel,
    input  logic                         lap_rd,
    output logic [MIN_W-1:0]             min_out,
    output logic [SEC_W-1:0]             sec_out,
    output logic                         running,
    output logic                         done,
    output logic                         lap_valid,
    output logic [MIN_W-1:0]             lap_min,
    output logic [SEC_W-1:0]             lap_sec,
    output logic [$clog2(LAP_DEPTH):0]   lap_count,
    output logic                         lap_ovf,
    output logic [1:0]                   state_dbg
);

    localparam int AW = $clog2(LAP_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [MIN_W-1:0] MIN_MAX  = MIN_W'(MIN_MOD - 1);
    localparam logic [SEC_W-1:0] SEC_MAX  = SEC_W'(SEC_MOD - 1);
    localparam logic [CW-1:0]    FULL_CNT = CW'(LAP_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RUN     = 2'd1,
        S_ADJUST  = 2'd2,
        S_EXPIRED = 2'd3
    } state_t;

    state_t state, state_n;

    logic             start_prev, lap_prev;
    logic             start_edge, lap_edge;
    logic             at_zero, fifo_full;
    logic [MIN_W-1:0] min_n;
    logic [SEC_W-1:0] sec_n;
    logic             done_n, ovf_n;
    logic             push_en, pop_en;

    logic [MIN_W+SEC_W-1:0] mem [LAP_DEPTH];
    logic [AW-1:0]          wr_ptr, rd_ptr;

    assign start_edge = start_stop & ~start_prev;
    assign lap_edge   = lap & ~lap_prev;
    assign at_zero    = (min_out == '0) && (sec_out == '0);
    assign fifo_full  = (lap_count == FULL_CNT);

    assign running    = (state == S_RUN);
    assign state_dbg  = state;

    // Read handshake: a pop happens in any cycle with lap_valid=1 and
    // lap_rd=1; lap_rd with lap_valid=0 is ignored. lap_min/lap_sec show
    // the FIFO head whenever lap_valid=1 and advance the cycle after a pop.
    assign lap_valid          = (lap_count != '0);
    assign {lap_min, lap_sec} = mem[rd_ptr];

    always_comb begin
        state_n = state;
        min_n   = min_out;
        sec_n   = sec_out;
        done_n  = 1'b0;
        ovf_n   = lap_ovf;
        push_en = 1'b0;
        pop_en  = lap_rd && lap_valid;

        if (clear) begin
            state_n = S_IDLE;
            min_n   = '0;
            sec_n   = '0;
            ovf_n   = 1'b0;
            pop_en  = 1'b0;
        end else if (adj) begin
            state_n = S_ADJUST;
            if (state == S_ADJUST && en_adj) begin
                // Fields adjust independently; no carry between them.
                if (sel)
                    sec_n = (sec_out == SEC_MAX) ? '0 : sec_out + SEC_W'(1);
                else
                    min_n = (min_out == MIN_MAX) ? '0 : min_out + MIN_W'(1);
            end
        end else begin
            case (state)
                S_IDLE: begin
                    if (start_edge && !(dir && at_zero))
                        state_n = S_RUN;
                end
                S_RUN: begin
                    // Lap is taken from the registered count, before any tick.
                    if (lap_edge) begin
                        if (!fifo_full || pop_en)
                            push_en = 1'b1;
                        else
                            ovf_n = 1'b1;
                    end
                    if (start_edge) begin
                        state_n = S_IDLE;
                    end else if (en_tick) begin
                        if (!dir) begin
                            if (sec_out == SEC_MAX) begin
                                sec_n = '0;
                                min_n = (min_out == MIN_MAX) ? '0 : min_out + MIN_W'(1);
                            end else begin
                                sec_n = sec_out + SEC_W'(1);
                            end
                        end else if (at_zero) begin
                            state_n = S_EXPIRED;
                            done_n  = 1'b1;
                        end else if (sec_out == '0) begin
                            sec_n = SEC_MAX;
                            min_n = min_out - MIN_W'(1);
                        end else begin
                            sec_n = sec_out - SEC_W'(1);
                        end
                    end
                end
                S_EXPIRED: begin
                    if (start_edge)
                        state_n = S_IDLE;
                end
                S_ADJUST: begin
                    state_n = S_IDLE;
                end
                default: state_n = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            min_out    <= '0;
            sec_out    <= '0;
            done       <= 1'b0;
            lap_ovf    <= 1'b0;
            start_prev <= 1'b0;
            lap_prev   <= 1'b0;
        end else begin
            state      <= state_n;
            min_out    <= min_n;
            sec_out    <= sec_n;
            done       <= done_n;
            lap_ovf    <= ovf_n;
            start_prev <= start_stop;
            lap_prev   <= lap;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            lap_count <= '0;
            for (int i = 0; i < LAP_DEPTH; i++)
                mem[i] <= '0;
        end else if (clear) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            lap_count <= '0;
        end else begin
            if (push_en) begin
                mem[wr_ptr] <= {min_out, sec_out};
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop_en)
                rd_ptr <= rd_ptr + AW'(1);
            lap_count <= lap_count + CW'(push_en) - CW'(pop_en);
        end
    end

endmodule

// File: tb/tb_lap_timer.sv
// Directed testbench for lap_timer: counting, expiry, adjust, lap FIFO,
// control priority and asynchronous reset.
module tb_lap_timer;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_ADJ  = 2'd2;
  localparam logic [1:0] ST_EXP  = 2'd3;

  logic       clk = 1'b0;
  logic       rst;
  logic       en_tick, en_adj, start_stop, lap, clear, dir, adj, sel, lap_rd;
  logic [6:0] min_out, lap_min;
  logic [5:0] sec_out, lap_sec;
  logic       running, done, lap_valid, lap_ovf;
  logic [2:0] lap_count;
  logic [1:0] state_dbg;

  int tests_run    = 0;
  int tests_failed = 0;

  lap_timer dut (
    .clk(clk), .rst(rst), .en_tick(en_tick), .en_adj(en_adj),
    .start_stop(start_stop), .lap(lap), .clear(clear), .dir(dir),
    .adj(adj), .sel(sel), .lap_rd(lap_rd),
    .min_out(min_out), .sec_out(sec_out), .running(running), .done(done),
    .lap_valid(lap_valid), .lap_min(lap_min), .lap_sec(lap_sec),
    .lap_count(lap_count), .lap_ovf(lap_ovf), .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  // driver tasks: inputs change 1 time unit after the rising edge
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    en_tick = 1'b1; cyc(); en_tick = 1'b0;
  endtask

  task automatic press_start();
    start_stop = 1'b1; cyc(); start_stop = 1'b0; cyc();
  endtask

  task automatic press_lap();
    lap = 1'b1; cyc(); lap = 1'b0; cyc();
  endtask

  task automatic preload(input int m, input int s);
    clear = 1'b1; cyc(); clear = 1'b0;
    adj = 1'b1; cyc();
    sel = 1'b0; en_adj = 1'b1; repeat (m) cyc(); en_adj = 1'b0;
    sel = 1'b1; en_adj = 1'b1; repeat (s) cyc(); en_adj = 1'b0;
    adj = 1'b0; cyc();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cyc(); cyc();
    tests_run++;
    if ({min_out, sec_out, running, done, lap_valid, lap_min, lap_sec, lap_count, lap_ovf, state_dbg} !== 35'd0) begin
      tests_failed++;
      $display("FAIL reset_values: got %h expected 0", {min_out, sec_out, running, done, lap_valid, lap_min, lap_sec, lap_count, lap_ovf, state_dbg});
    end
    rst = 1'b0;
    cyc();
  endtask

  task automatic test_up_wrap();
    preload(59, 58);
    dir = 1'b0;
    start_stop = 1'b1; cyc(); start_stop = 1'b0;
    tests_run++;
    if (running !== 1'b1) begin
      tests_failed++; $display("FAIL up_start_running: got %b expected 1", running);
    end
    cyc();
    tick();
    tests_run++;
    if ({min_out, sec_out} !== {7'd59, 6'd59}) begin
      tests_failed++; $display("FAIL up_tick1: got %0d:%0d expected 59:59", min_out, sec_out);
    end
    tick();
    tests_run++;
    if ({min_out, sec_out, running} !== {7'd0, 6'd0, 1'b1}) begin
      tests_failed++; $display("FAIL up_wrap: got %0d:%0d run=%b expected 0:0 run=1", min_out, sec_out, running);
    end
    tick();
    tests_run++;
    if ({min_out, sec_out, running} !== {7'd0, 6'd1, 1'b1}) begin
      tests_failed++; $display("FAIL up_tick3: got %0d:%0d run=%b expected 0:1 run=1", min_out, sec_out, running);
    end
    press_start();
    tests_run++;
    if ({running, state_dbg, min_out, sec_out} !== {1'b0, ST_IDLE, 7'd0, 6'd1}) begin
      tests_failed++; $display("FAIL up_stop: got run=%b st=%0d %0d:%0d expected run=0 st=0 0:1", running, state_dbg, min_out, sec_out);
    end
  endtask

  task automatic test_countdown();
    preload(0, 2);
    dir = 1'b1;
    press_start();
    tests_run++;
    if (running !== 1'b1) begin
      tests_failed++; $display("FAIL down_start: got run=%b expected 1", running);
    end
    tick();
    tests_run++;
    if ({min_out, sec_out} !== {7'd0, 6'd1}) begin
      tests_failed++; $display("FAIL down_tick1: got %0d:%0d expected 0:1", min_out, sec_out);
    end
    tick();
    tests_run++;
    if ({min_out, sec_out, done, running} !== {7'd0, 6'd0, 1'b0, 1'b1}) begin
      tests_failed++; $display("FAIL down_tick2: got %0d:%0d done=%b run=%b expected 0:0 done=0 run=1", min_out, sec_out, done, running);
    end
    tick();
    tests_run++;
    if ({done, running, state_dbg, min_out, sec_out} !== {1'b1, 1'b0, ST_EXP, 7'd0, 6'd0}) begin
      tests_failed++; $display("FAIL down_expire: got done=%b run=%b st=%0d %0d:%0d expected done=1 run=0 st=3 0:0", done, running, state_dbg, min_out, sec_out);
    end
    cyc();
    tests_run++;
    if ({done, state_dbg} !== {1'b0, ST_EXP}) begin
      tests_failed++; $display("FAIL down_done_width: got done=%b st=%0d expected done=0 st=3", done, state_dbg);
    end
    press_start();
    tests_run++;
    if (state_dbg !== ST_IDLE) begin
      tests_failed++; $display("FAIL expired_to_idle: got st=%0d expected 0", state_dbg);
    end
    press_start();
    tests_run++;
    if ({state_dbg, running} !== {ST_IDLE, 1'b0}) begin
      tests_failed++; $display("FAIL zero_start_ignored: got st=%0d run=%b expected st=0 run=0", state_dbg, running);
    end
  endtask

  task automatic test_borrow();
    preload(5, 0);
    dir = 1'b1;
    press_start();
    tick();
    tests_run++;
    if ({min_out, sec_out} !== {7'd4, 6'd59}) begin
      tests_failed++; $display("FAIL borrow: got %0d:%0d expected 4:59", min_out, sec_out);
    end
    press_start();
  endtask

  task automatic test_lap_fifo();
    preload(0, 0);
    dir = 1'b0;
    press_start();
    for (int i = 1; i <= 4; i++) begin
      tick();
      press_lap();
    end
    tests_run++;
    if ({lap_count, lap_ovf, lap_valid, lap_min, lap_sec} !== {3'd4, 1'b0, 1'b1, 7'd0, 6'd1}) begin
      tests_failed++; $display("FAIL lap_fill: got cnt=%0d ovf=%b v=%b head=%0d:%0d expected cnt=4 ovf=0 v=1 head=0:1", lap_count, lap_ovf, lap_valid, lap_min, lap_sec);
    end
    tick();
    lap = 1'b1; lap_rd = 1'b1; cyc(); lap = 1'b0; lap_rd = 1'b0; cyc();
    tests_run++;
    if ({lap_count, lap_ovf, lap_min, lap_sec} !== {3'd4, 1'b0, 7'd0, 6'd2}) begin
      tests_failed++; $display("FAIL lap_push_pop_full: got cnt=%0d ovf=%b head=%0d:%0d expected cnt=4 ovf=0 head=0:2", lap_count, lap_ovf, lap_min, lap_sec);
    end
    tick();
    press_lap();
    tests_run++;
    if ({lap_count, lap_ovf, lap_min, lap_sec} !== {3'd4, 1'b1, 7'd0, 6'd2}) begin
      tests_failed++; $display("FAIL lap_overflow: got cnt=%0d ovf=%b head=%0d:%0d expected cnt=4 ovf=1 head=0:2", lap_count, lap_ovf, lap_min, lap_sec);
    end
    for (int k = 2; k <= 5; k++) begin
      tests_run++;
      if ({lap_valid, lap_min, lap_sec} !== {1'b1, 7'd0, 6'(k)}) begin
        tests_failed++; $display("FAIL lap_pop_head%0d: got v=%b %0d:%0d expected v=1 0:%0d", k, lap_valid, lap_min, lap_sec, k);
      end
      lap_rd = 1'b1; cyc(); lap_rd = 1'b0;
    end
    tests_run++;
    if ({lap_valid, lap_count, lap_ovf} !== {1'b0, 3'd0, 1'b1}) begin
      tests_failed++; $display("FAIL lap_drained: got v=%b cnt=%0d ovf=%b expected v=0 cnt=0 ovf=1", lap_valid, lap_count, lap_ovf);
    end
    lap_rd = 1'b1; cyc(); lap_rd = 1'b0;
    tests_run++;
    if ({lap_valid, lap_count} !== {1'b0, 3'd0}) begin
      tests_failed++; $display("FAIL lap_rd_empty: got v=%b cnt=%0d expected v=0 cnt=0", lap_valid, lap_count);
    end
    press_start();
  endtask

  task automatic test_adjust();
    clear = 1'b1; cyc(); clear = 1'b0;
    adj = 1'b1; cyc();
    sel = 1'b0; en_adj = 1'b1; repeat (61) cyc(); en_adj = 1'b0;
    tests_run++;
    if ({min_out, sec_out, state_dbg} !== {7'd1, 6'd0, ST_ADJ}) begin
      tests_failed++; $display("FAIL adj_min_wrap: got %0d:%0d st=%0d expected 1:0 st=2", min_out, sec_out, state_dbg);
    end
    tick();
    tests_run++;
    if ({min_out, sec_out} !== {7'd1, 6'd0}) begin
      tests_failed++; $display("FAIL adj_tick_ignored: got %0d:%0d expected 1:0", min_out, sec_out);
    end
    sel = 1'b1; en_adj = 1'b1; repeat (3) cyc(); en_adj = 1'b0;
    tests_run++;
    if ({min_out, sec_out} !== {7'd1, 6'd3}) begin
      tests_failed++; $display("FAIL adj_sec: got %0d:%0d expected 1:3", min_out, sec_out);
    end
    en_adj = 1'b1; repeat (57) cyc(); en_adj = 1'b0;
    tests_run++;
    if ({min_out, sec_out} !== {7'd1, 6'd0}) begin
      tests_failed++; $display("FAIL adj_sec_no_carry: got %0d:%0d expected 1:0", min_out, sec_out);
    end
    adj = 1'b0; cyc();
    tests_run++;
    if ({state_dbg, running} !== {ST_IDLE, 1'b0}) begin
      tests_failed++; $display("FAIL adj_release: got st=%0d run=%b expected st=0 run=0", state_dbg, running);
    end
  endtask

  task automatic test_priority();
    preload(0, 5);
    dir = 1'b0;
    press_start();
    lap = 1'b1; start_stop = 1'b1; cyc(); lap = 1'b0; start_stop = 1'b0; cyc();
    tests_run++;
    if ({running, lap_count, lap_min, lap_sec} !== {1'b0, 3'd1, 7'd0, 6'd5}) begin
      tests_failed++; $display("FAIL lap_and_stop: got run=%b cnt=%0d head=%0d:%0d expected run=0 cnt=1 head=0:5", running, lap_count, lap_min, lap_sec);
    end
    press_start();
    tick();
    clear = 1'b1; start_stop = 1'b1; cyc(); clear = 1'b0; start_stop = 1'b0; cyc();
    tests_run++;
    if ({min_out, sec_out, state_dbg, lap_valid, lap_count} !== {7'd0, 6'd0, ST_IDLE, 1'b0, 3'd0}) begin
      tests_failed++; $display("FAIL clear_priority: got %0d:%0d st=%0d v=%b cnt=%0d expected 0:0 st=0 v=0 cnt=0", min_out, sec_out, state_dbg, lap_valid, lap_count);
    end
  endtask

  task automatic test_async_reset();
    preload(0, 0);
    dir = 1'b0;
    press_start();
    tick(); press_lap();
    tick(); press_lap();
    tick();
    tests_run++;
    if ({running, lap_count} !== {1'b1, 3'd2}) begin
      tests_failed++; $display("FAIL rst_precondition: got run=%b cnt=%0d expected run=1 cnt=2", running, lap_count);
    end
    #3 rst = 1'b1;
    #1;
    tests_run++;
    if ({min_out, sec_out, running, done, lap_valid, lap_min, lap_sec, lap_count, lap_ovf, state_dbg} !== 35'd0) begin
      tests_failed++;
      $display("FAIL async_reset: got %h expected 0", {min_out, sec_out, running, done, lap_valid, lap_min, lap_sec, lap_count, lap_ovf, state_dbg});
    end
    cyc();
    rst = 1'b0;
    cyc();
  endtask

  initial begin
    rst = 1'b1;
    en_tick = 1'b0; en_adj = 1'b0; start_stop = 1'b0; lap = 1'b0;
    clear = 1'b0; dir = 1'b0; adj = 1'b0; sel = 1'b0; lap_rd = 1'b0;
    test_reset();
    test_up_wrap();
    test_countdown();
    test_borrow();
    test_lap_fifo();
    test_adjust();
    test_priority();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/lap_timer.md
# lap_timer

Parametrised stopwatch core: the next-generation replacement for the fixed 00:00–59:59 up-counter. It adds count-down mode with expiry, parametrised field moduli, and a lap-capture FIFO with a read handshake. It runs in the master clock domain, is driven by the clock divider's enable pulses and the debounced button/switch levels, and feeds binary minute/second values to the BCD and seven-segment path.

## Interface
- MIN_MOD, 60: minute field modulus (minutes run 0..MIN_MOD-1); 2..2^MIN_W
- SEC_MOD, 60: second field modulus; 2..2^SEC_W
- MIN_W, 7: minute field width
- SEC_W, 6: second field width
- LAP_DEPTH, 4: lap FIFO entries; power of two, ≥2
---
- clk  in  1  master clock
- rst  in  1  asynchronous, active-high reset
- en_tick  in  1  one-cycle count pulse (1 Hz)
- en_adj  in  1  one-cycle adjust pulse (2 Hz)
- start_stop  in  1  debounced level; rising edge toggles run/stop
- lap  in  1  debounced level; rising edge captures a lap
- clear  in  1  synchronous clear, level
- dir  in  1  0 = count up, 1 = count down; sampled on every tick
- adj  in  1  adjust mode, level
- sel  in  1  adjust field select: 0 = minutes, 1 = seconds
- lap_rd  in  1  pop FIFO head; honoured only when lap_valid=1
- min_out  out  MIN_W  current minutes
- sec_out  out  SEC_W  current seconds
- running  out  1  high in RUN
- done  out  1  one-cycle pulse on countdown expiry
- lap_valid  out  1  FIFO not empty
- lap_min  out  MIN_W  FIFO head minutes (first-word-fall-through)
- lap_sec  out  SEC_W  FIFO head seconds
- lap_count  out  $clog2(LAP_DEPTH)+1  FIFO occupancy
- lap_ovf  out  1  sticky: a capture was dropped because the FIFO was full

## Operation
- States: IDLE, RUN, ADJUST, EXPIRED. Reset state: IDLE.
- Rising edges come from internal prev-registers (edge = level & ~prev). The prev-registers reset to 0.
- Control priority per cycle: clear > adj > state logic.
  - clear: count=0, state=IDLE, FIFO emptied, lap_ovf=0.
- Any state with adj=1 goes to ADJUST.
  - In ADJUST, en_adj increments the selected field modulo its MOD, with no carry between fields.
  - When adj falls, the state goes to IDLE.
- IDLE:
  - start edge goes to RUN.
  - Exception: with dir=1 and count 00:00, the start edge is ignored and the state stays IDLE.
- RUN:
  - start edge goes to IDLE.
  - en_tick with dir=0: sec+1. At SEC_MOD-1, sec wraps to 0 and min+1. At MOD-1:MOD-1, both wrap to 00:00 and the block stays in RUN.
  - en_tick with dir=1, count ≠ 00:00: sec-1. At sec=0, sec becomes SEC_MOD-1 and min-1.
  - en_tick with dir=1, count = 00:00: go to EXPIRED, done=1 for one cycle, count holds 00:00.
- EXPIRED: start edge goes to IDLE. Count holds.
- Lap capture applies only in RUN. A lap edge pushes {min_out, sec_out} as registered that cycle, i.e. the pre-tick value if en_tick coincides.
  - Capture when full is dropped and sets lap_ovf.
  - If full and lap_rd=1 in the same cycle, the pop and push both occur and lap_ovf is not set.
- A start edge and a lap edge in the same cycle in RUN: the lap is captured, then the block stops.
- lap_rd while empty is ignored. lap_min/lap_sec are don't-care while lap_valid=0.

## Timing
- All outputs are registered and take effect on the clk edge after the qualifying input cycle.
- Reset values: min_out=0, sec_out=0, running=0, done=0, lap_valid=0, lap_min=0, lap_sec=0, lap_count=0, lap_ovf=0.
- Reset asserted mid-count or mid-FIFO-operation clears everything immediately, asynchronously. Deassertion is synchronous to clk externally.
- start edge at cycle n: running reflects the new state at n+1. A tick at n+1 is counted.
- Push at cycle n: lap_valid=1 and lap_count updated at n+1. Pop at n: the next head appears at n+1.
- done is high exactly one cycle, one cycle after the expiring tick.

## Test plan
- Up-count wrap: MIN_MOD=SEC_MOD=60, RUN, dir=0, preload 59:58 via ADJUST, 3 ticks → 59:59, 00:00, 00:01; running stays 1.
- Countdown expiry: preload 00:02, dir=1, start, 3 ticks → 00:01, 00:00, then done pulse one cycle, state EXPIRED, running=0. Next start edge → IDLE. Next start edge with 00:00 → stays IDLE.
- Borrow: dir=1 at 05:00, one tick → 04:59.
- Lap FIFO, LAP_DEPTH=4: 5 lap edges at 00:01..00:05 → lap_count=4, lap_ovf=1. Pops return 00:01..00:04, then lap_valid=0. Simultaneous push and pop when full → lap_count stays 4, lap_ovf unchanged.
- Adjust: adj=1, sel=0, 61 en_adj pulses from 00:00 → 01:00. Minutes wrap at 59 with no carry. Ticks are ignored while in ADJUST. Releasing adj → IDLE.
- Priority/reset: clear together with a start edge → 00:00, IDLE, FIFO empty. rst asserted mid-RUN with 2 laps stored → all outputs at reset values before the next clk edge.
